reg_file_mp: RTL and testbench
==============================

Name: reg_file_mp

Overview:
- Parametrised successor to the core integer register file, used by the decode stage of the pipelined core.
- Configurable data width, register count and number of combinational read ports; one synchronous write port.
- After reset, a clear sequencer zeroes every entry, one entry per cycle.
- A `ready` flag tells the pipeline when the file contents are valid. x0 is hardwired to zero.

Parameters:
- XLEN, 32, data width of each register in bits.
- NREG, 32, number of registers; power of two, >= 2.
- NRD, 2, number of read ports, >= 1.
- AW, $clog2(NREG), address width; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- write_en  in  1  write request; sampled on the rising edge.
- write_addr  in  AW  destination register.
- write_value  in  XLEN  data to write.
- rs_addr  in  NRD*AW  read addresses, flattened; port i uses bits [i*AW +: AW].
- rs_data  out  NRD*XLEN  read data, flattened; port i uses bits [i*XLEN +: XLEN].
- ready  out  1  high once the clear sequence has completed.

Behaviour:
- Interface is fixed: one clock (clk); reset is synchronous and active-high (reset).
- State machine has two states, CLEAR and RUN, plus clear index idx (AW+1 bits).
- While reset is high at a clock edge:
  - state <= CLEAR, idx <= 0, ready <= 0.
  - No storage entry is written.
- CLEAR state, reset low, each edge:
  - mem[idx] <= 0 and idx <= idx+1.
  - On the edge that clears entry NREG-1: state <= RUN and ready <= 1.
  - Result: ready rises exactly NREG edges after the first edge with reset low.
- CLEAR state, write_en: ignored and dropped. There is no backpressure; the pipeline must gate its writes on ready.
- Reset asserted mid-clear: the sequence restarts from idx 0 and takes the full NREG cycles again.
- RUN state:
  - Write: write_en=1 and write_addr!=0 gives mem[write_addr] <= write_value on the edge.
  - Write to address 0 is discarded.
- Read: rs_data port i is combinational, with zero latency.
  - 0 if ready=0.
  - 0 if rs_addr_i == 0.
  - Otherwise mem[rs_addr_i], subject to the Optional Feature below.
- Multiple read ports with the same address return identical data.
- Reset value of outputs: ready=0; every rs_data port reads 0, because ready=0.
- No X may propagate to rs_data after reset. Storage contents before the clear completes are don't-care and masked.

Optional Feature:
- Macro: REG_FILE_BYPASS_EN.
- Defined: in RUN, a port with write_en=1, write_addr==rs_addr_i and rs_addr_i!=0 returns write_value in the same cycle (write-to-read forwarding). This removes the WB->ID hazard.
- Not defined: such a port returns the old mem value. The new value becomes visible the cycle after the write edge.
- Both builds: a write to address 0 never forwards, and rs_data stays 0 while ready=0.

Test Plan:
- Reset then clear timing: reset high 2 cycles, then low. Required: ready=0 for exactly 32 edges, then 1; all ports read 0 throughout.
- Write then read: write addr 5 = 0xDEADBEEF, then read port0=5, port1=5. Required: both return 0xDEADBEEF the next cycle.
- x0 protection: write addr 0 = 0xFFFFFFFF. Required: read addr 0 returns 0 on every port.
- Same-cycle write/read, addr 7 = 0x12345678, old value 0xAAAA0000. Required: returns 0x12345678 with REG_FILE_BYPASS_EN defined; 0xAAAA0000 without it.
- Reset mid-clear: assert reset at clear cycle 10 for 1 cycle. Required: ready rises 32 edges after reset deasserts; a register written before the reset reads 0.
- Write during CLEAR: write_en=1, addr 3 = 0x55 at clear cycle 4. Required: after ready=1, addr 3 reads 0.
- Alternative configuration, XLEN=64, NREG=16, NRD=3: write addr 15 = 0x0123456789ABCDEF. Required: all three ports read it back; ready rises after 16 edges.

Source files
------------

// File: rtl/reg_file_mp_if.sv
// Register file bus: write port, flattened read ports and the ready flag.
interface reg_file_mp_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2
);
  localparam int AW = $clog2(NREG);

  logic                 write_en;
  logic [AW-1:0]        write_addr;
  logic [XLEN-1:0]      write_value;
  logic [NRD*AW-1:0]    rs_addr;
  logic [NRD*XLEN-1:0]  rs_data;
  logic                 ready;

  modport master (output write_en, write_addr, write_value, rs_addr,
                  input  rs_data, ready);
  modport slave  (input  write_en, write_addr, write_value, rs_addr,
                  output rs_data, ready);
endinterface

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with post-reset clear sequencer and hardwired x0.
// Define REG_FILE_BYPASS_EN to forward a same-cycle write to matching read ports.
module reg_file_mp_rd_port #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic                       ready,
  input  logic [AW-1:0]              rd_addr,
  input  logic [NREG-1:0][XLEN-1:0]  mem,
  input  logic                       fwd_vld,
  input  logic [AW-1:0]              fwd_addr,
  input  logic [XLEN-1:0]            fwd_data,
  output logic [XLEN-1:0]            rd_data
);
  always_comb begin
    rd_data = '0;
    // fwd_vld already excludes x0, so the x0 check below still wins
    if (ready && rd_addr != '0) begin
      if (fwd_vld && fwd_addr == rd_addr) rd_data = fwd_data;
      else                                rd_data = mem[rd_addr];
    end
  end
endmodule

module reg_file_mp #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2
) (
  input  logic         clk,
  input  logic         reset,
  reg_file_mp_if.slave bus
);
  localparam int AW = $clog2(NREG);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                    state_q, state_d;
  logic [AW:0]               idx_q, idx_d;
  logic                      ready_q, ready_d;
  logic                      mem_we;
  logic [AW-1:0]             mem_waddr;
  logic [XLEN-1:0]           mem_wdata;
  logic [NREG-1:0][XLEN-1:0] mem;
  logic [NRD-1:0][XLEN-1:0]  rd_data;
  logic                      fwd_vld;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      idx_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
    end
  end

  // Storage has no reset; contents are masked until the clear finishes
  always_ff @(posedge clk) begin
    if (!reset && mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ready_d   = ready_q;
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    case (state_q)
      CLEAR: begin
        // Pipeline writes are dropped here; the clear owns the write port
        mem_we    = 1'b1;
        mem_waddr = idx_q[AW-1:0];
        idx_d     = idx_q + (AW+1)'(1);
        if (idx_q[AW-1:0] == AW'(NREG-1)) begin
          state_d = RUN;
          ready_d = 1'b1;
        end
      end
      RUN: begin
        if (bus.write_en && bus.write_addr != '0) begin
          mem_we    = 1'b1;
          mem_waddr = bus.write_addr;
          mem_wdata = bus.write_value;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

`ifdef REG_FILE_BYPASS_EN
  assign fwd_vld = ready_q && bus.write_en && (bus.write_addr != '0);
`else
  assign fwd_vld = 1'b0;
`endif

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    reg_file_mp_rd_port #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) u_rd (
      .ready    (ready_q),
      .rd_addr  (bus.rs_addr[i*AW +: AW]),
      .mem      (mem),
      .fwd_vld  (fwd_vld),
      .fwd_addr (bus.write_addr),
      .fwd_data (bus.write_value),
      .rd_data  (rd_data[i])
    );
  end

  assign bus.rs_data = rd_data;
  assign bus.ready   = ready_q;
endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench: default 32x32/2-port file plus a 64-bit x16/3-port instance.
module tb_reg_file_mp;
`ifdef REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  reg_file_mp_if #(.XLEN(32), .NREG(32), .NRD(2)) ifa ();
  reg_file_mp_if #(.XLEN(64), .NREG(16), .NRD(3)) ifb ();

  reg_file_mp #(.XLEN(32), .NREG(32), .NRD(2)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa.slave));
  reg_file_mp #(.XLEN(64), .NREG(16), .NRD(3)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb.slave));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    ifa.write_en = 1'b0; ifa.write_addr = '0; ifa.write_value = '0;
    ifb.write_en = 1'b0; ifb.write_addr = '0; ifb.write_value = '0;
    ifa.rs_addr = {5'd31, 5'd5};
    ifb.rs_addr = {4'd15, 4'd2, 4'd1};

    // two edges with reset high
    repeat (2) @(negedge clk);
    chk("rst_ready_a", 64'(ifa.ready), 64'd0);
    chk("rst_data_a",  64'(ifa.rs_data), 64'd0);
    chk("rst_ready_b", 64'(ifb.ready), 64'd0);
    chk("rst_data_b0", ifb.rs_data[63:0], 64'd0);
    reset = 1'b0;

    // clear sequence; a write is attempted on edge 5 (addr 3 already cleared)
    for (int e = 1; e <= 32; e++) begin
      @(negedge clk);
      chk($sformatf("clr_ready_a_e%0d", e), 64'(ifa.ready), 64'(e >= 32));
      chk($sformatf("clr_ready_b_e%0d", e), 64'(ifb.ready), 64'(e >= 16));
      chk($sformatf("clr_data_a_e%0d", e), 64'(ifa.rs_data), 64'd0);
      chk($sformatf("clr_data_b_e%0d", e), ifb.rs_data[191:128], 64'd0);
      if (e == 4) begin
        ifa.write_en = 1'b1; ifa.write_addr = 5'd3; ifa.write_value = 32'h55;
      end
      if (e == 5) ifa.write_en = 1'b0;
    end

    ifa.rs_addr = {5'd3, 5'd3};
    #1;
    chk("clr_drop_p0", 64'(ifa.rs_data[31:0]),  64'd0);
    chk("clr_drop_p1", 64'(ifa.rs_data[63:32]), 64'd0);

    // write then read, both configurations
    ifa.write_en = 1'b1; ifa.write_addr = 5'd5; ifa.write_value = 32'hDEADBEEF;
    ifa.rs_addr  = {5'd5, 5'd5};
    ifb.write_en = 1'b1; ifb.write_addr = 4'd15; ifb.write_value = 64'h0123456789ABCDEF;
    ifb.rs_addr  = {4'd15, 4'd15, 4'd15};
    #1;
    chk("wr5_same_p0", 64'(ifa.rs_data[31:0]), BYP ? 64'hDEADBEEF : 64'd0);
    chk("wr15_same_b0", ifb.rs_data[63:0], BYP ? 64'h0123456789ABCDEF : 64'd0);
    @(negedge clk);
    ifa.write_en = 1'b0; ifb.write_en = 1'b0;
    #1;
    chk("wr5_p0", 64'(ifa.rs_data[31:0]),  64'hDEADBEEF);
    chk("wr5_p1", 64'(ifa.rs_data[63:32]), 64'hDEADBEEF);
    chk("wr15_b0", ifb.rs_data[63:0],    64'h0123456789ABCDEF);
    chk("wr15_b1", ifb.rs_data[127:64],  64'h0123456789ABCDEF);
    chk("wr15_b2", ifb.rs_data[191:128], 64'h0123456789ABCDEF);

    // x0 protection: never written, never forwarded
    ifa.write_en = 1'b1; ifa.write_addr = 5'd0; ifa.write_value = 32'hFFFFFFFF;
    ifa.rs_addr  = {5'd0, 5'd0};
    #1;
    chk("x0_same_p0", 64'(ifa.rs_data[31:0]),  64'd0);
    chk("x0_same_p1", 64'(ifa.rs_data[63:32]), 64'd0);
    @(negedge clk);
    ifa.write_en = 1'b0;
    #1;
    chk("x0_p0", 64'(ifa.rs_data[31:0]),  64'd0);
    chk("x0_p1", 64'(ifa.rs_data[63:32]), 64'd0);

    // same-cycle write/read at addr 7, old value 0xAAAA0000
    ifa.write_en = 1'b1; ifa.write_addr = 5'd7; ifa.write_value = 32'hAAAA0000;
    @(negedge clk);
    ifa.write_value = 32'h12345678;
    ifa.rs_addr = {5'd5, 5'd7};
    #1;
    chk("byp7_p0", 64'(ifa.rs_data[31:0]), BYP ? 64'h12345678 : 64'hAAAA0000);
    chk("byp7_p1_other", 64'(ifa.rs_data[63:32]), 64'hDEADBEEF);
    @(negedge clk);
    ifa.write_en = 1'b0;
    #1;
    chk("byp7_after", 64'(ifa.rs_data[31:0]), 64'h12345678);

    // reset mid-clear: reg 20 written, then reset, clear to idx 10, reset again
    ifa.write_en = 1'b1; ifa.write_addr = 5'd20; ifa.write_value = 32'h99;
    ifa.rs_addr = {5'd7, 5'd20};
    @(negedge clk);
    ifa.write_en = 1'b0;
    #1;
    chk("r20_pre", 64'(ifa.rs_data[31:0]), 64'h99);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_ready_a", 64'(ifa.ready), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int e = 1; e <= 32; e++) begin
      @(negedge clk);
      chk($sformatf("re_ready_a_e%0d", e), 64'(ifa.ready), 64'(e >= 32));
      chk($sformatf("re_ready_b_e%0d", e), 64'(ifb.ready), 64'(e >= 16));
    end
    #1;
    chk("r20_cleared", 64'(ifa.rs_data[31:0]),  64'd0);
    chk("r7_cleared",  64'(ifa.rs_data[63:32]), 64'd0);
    chk("b15_cleared", ifb.rs_data[63:0], 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
